gf_inverse: RTL and testbench
=============================

# gf_inverse

- Iterative GF(2^8) multiplicative-inverse unit, the stage directly upstream of `s_box_forward`.
- Computes `odata = idata^254` in GF(2^8) modulo x^8+x^4+x^3+x+1, so `0x00` maps to `0x00`. Its output is exactly the "inverse byte" that the affine stage consumes.
- Uses a single-transaction valid/ready handshake on both sides and a fixed 7-cycle compute loop with one squarer and one multiplier.

## Interface
- `POLY`, default `8'h1B`: low byte of the reduction polynomial. Bit 8 is implicit.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `idata` input, 8 bits: byte to invert. Sampled only on input handshake.
- `ivalid` input, 1 bit: upstream presents valid `idata`.
- `iready` output, 1 bit: block can accept a byte. High only in IDLE.
- `odata` output, 8 bits: multiplicative inverse. Valid while `ovalid` is high.
- `ovalid` output, 1 bit: `odata` holds a completed result.
- `oready` input, 1 bit: downstream accepts `odata` this cycle.

## Operation
- **Input handshake:** occurs on a rising edge with `ivalid && iready`.
- **Output handshake:** occurs on a rising edge with `ovalid && oready`.
- **FSM states:**
  - IDLE → COMPUTE on input handshake. Load `x <= idata`, `r <= 8'h01`, `cnt <= 0`.
  - COMPUTE, on every edge:
    - `x <= x·x`
    - `r <= r·(x·x)`, i.e. multiply by the new square in the same cycle
    - `cnt <= cnt+1`
  - COMPUTE → DONE on the edge where `cnt == 6`, which is the 7th update. The final `r` is registered into `odata`.
  - DONE → IDLE on output handshake.
- **Result:** after 7 updates, `r = a^(2+4+…+128) = a^254`.
- **GF multiply (combinational, 8-bit only):** shift-and-add over 8 bits. Whenever the shifted-out bit 7 is 1, XOR `POLY` into the shifted value. No wider intermediates.
- **Zero input:** `x` stays 0, so `r` becomes 0. No special case in the RTL.
- **Output stability:** `odata` is stable from `ovalid` rise until the output handshake. It is not updated in IDLE or COMPUTE and keeps its last result in IDLE.
- **Busy behaviour:** `ivalid` while not in IDLE is ignored. `idata` is not sampled and upstream must hold it.
- `oready` outside DONE is ignored.
- **Single transaction:** at most one transaction in flight. No accept in DONE, even when an output handshake happens on the same edge.
- **`POLY` reconfiguration:** changing `POLY` changes the field. With the default, the result must equal the AES inverse table.

## Timing
- **Reset values:**
  - state IDLE
  - `iready` 1
  - `ovalid` 0
  - `odata` 8'h00
  - `x`, `r`, `cnt` all 0
- **Reset mid-operation:** `rst` in COMPUTE or DONE discards the transaction. `ovalid` is 0 after the reset edge and no result is ever presented.
- **Latency:** accept on edge E0. COMPUTE updates on E1–E7. `ovalid` goes high after E7, i.e. 7 cycles after accept.
- `iready` falls after E0 and rises after the output-handshake edge.
- **Throughput with `oready` tied high:** output handshake on E8, IDLE after E8, next accept on E9. One byte per 9 cycles.
- **Backpressure:** `oready` low holds DONE indefinitely, with `ovalid` and `odata` unchanged.
- `cnt` is 3 bits and never wraps during normal operation. It is cleared on accept.
- `iready`, `ovalid` and `odata` are functions of registered state only. No combinational path from `ivalid`/`oready` to any output.

## Test plan
- **Reset:** assert `rst` 2 cycles → `iready=1`, `ovalid=0`, `odata=0x00`.
- **Latency and handshake, `oready` tied 1:**
  - `idata=0x53` → `ovalid` exactly 7 cycles after accept with `odata=0xCA`.
  - Then `0x3D`→`0xBB`, `0x02`→`0x8D`, `0xFF`→`0x1C`, `0x01`→`0x01`.
  - Accept period is 9 cycles.
- **Zero:** `idata=0x00` → `odata=0x00` with normal latency.
- **Backpressure and busy:**
  - `idata=0x53`, hold `oready=0` for 5 cycles after `ovalid` → `odata=0xCA` held and `iready=0` throughout.
  - A second `ivalid` with `0x02` during COMPUTE or DONE is not accepted until IDLE. It then yields `0x8D`.
- **Reset mid-compute:** pulse `rst` 3 cycles after accepting `0x53` → no `ovalid` appears. A fresh `0x3D` afterwards gives `0xBB`.
- **Exhaustive sweep:** all 256 inputs with random `ivalid`/`oready` gaps.
  - Every `odata` equals the AES inverse table.
  - Every `odata·idata=0x01` for nonzero `idata`.
  - Results appear in order and no transaction is dropped or duplicated.

Source files
------------

// File: rtl/gf_inverse.sv
// Iterative GF(2^8) multiplicative inverse: odata = idata^254 over x^8 + POLY.
// One byte in flight; seven square-and-multiply steps between accept and result.
module gf_inverse #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] idata,
  input  logic       ivalid,
  output logic       iready,
  output logic [7:0] odata,
  output logic       ovalid,
  input  logic       oready
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // iready/ovalid decode registered state only, so no input reaches an output.

  logic [1:0] state;
  logic [7:0] x;
  logic [7:0] r;
  logic [2:0] cnt;
  logic [7:0] x_sq;
  logic [7:0] r_next;

  // Shift-and-add multiply kept to 8 bits: reduce each time bit 7 shifts out.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      if (s[7]) s = {s[6:0], 1'b0} ^ POLY;
      else      s = {s[6:0], 1'b0};
    end
    return p;
  endfunction

  always_comb begin
    x_sq   = gf_mul(x, x);
    r_next = gf_mul(r, x_sq);
  end

  assign iready = (state == IDLE);
  assign ovalid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x     <= 8'h00;
      r     <= 8'h00;
      cnt   <= 3'd0;
      odata <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (ivalid) begin
            x     <= idata;
            r     <= 8'h01;
            cnt   <= 3'd0;
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          // r accumulates a^2 * a^4 * ... * a^128 = a^254 over seven steps.
          x   <= x_sq;
          r   <= r_next;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd6) begin
            odata <= r_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (oready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_inverse.sv
// Bench for gf_inverse: directed handshake/latency/backpressure/reset steps,
// then a full 256-value sweep with random gaps, checked through an expected queue.
module tb_gf_inverse;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] idata;
  logic       ivalid;
  logic       iready;
  logic [7:0] odata;
  logic       ovalid;
  logic       oready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int accept_cyc = 0;
  int rise_count = 0;
  int out_count  = 0;
  int acc_count  = 0;
  logic ovalid_prev = 1'b0;
  logic sweep_done  = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] in_q[$];

  gf_inverse #(.POLY(8'h1B)) dut (
    .clk   (clk),
    .rst   (rst),
    .idata (idata),
    .ivalid(ivalid),
    .iready(iready),
    .odata (odata),
    .ovalid(ovalid),
    .oready(oready)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference field model: full carry-less product reduced by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 14; k >= 8; k--)
      if (p[k]) p = p ^ (16'h011B << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int b = 1; b < 256; b++)
      if (ref_mul(a, 8'(b)) == 8'h01) return 8'(b);
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    total++;
    bad++;
    $error("FAIL %s bound expired", tag);
  endtask

  // Driver: present d until accepted, then push its expected result.
  task automatic send(input logic [7:0] d, input logic [7:0] e);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    idata  = d;
    ivalid = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clk);
      if (iready) ok = 1'b1;
      n++;
    end
    @(posedge clk);
    #1;
    if (ok) begin
      accept_cyc = cyc;
      acc_count++;
      exp_q.push_back(e);
      in_q.push_back(d);
    end else begin
      fail_now("accept_timeout");
    end
    ivalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ovalid) && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n >= 400) fail_now("drain_timeout");
    #1;
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: sampled mid-cycle, output handshake when ovalid && oready.
  always @(negedge clk) begin
    if (rst) begin
      ovalid_prev <= 1'b0;
    end else begin
      if (ovalid && !ovalid_prev) begin
        rise_count++;
        check_int("latency", cyc - accept_cyc, 7);
      end
      ovalid_prev <= ovalid;
      if (ovalid && oready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          logic [7:0] e;
          logic [7:0] a;
          e = exp_q.pop_front();
          a = in_q.pop_front();
          check("odata", odata, e);
          if (a != 8'h00) check("inv_product", ref_mul(odata, a), 8'h01);
        end
      end
    end
  end

  initial begin
    int prev_acc;
    int rises;
    int n;
    rst    = 1'b1;
    idata  = 8'h00;
    ivalid = 1'b0;
    oready = 1'b1;

    // Reset held two cycles
    cycles(2);
    check("rst_iready", {7'd0, iready}, 8'h01);
    check("rst_ovalid", {7'd0, ovalid}, 8'h00);
    check("rst_odata", odata, 8'h00);
    rst = 1'b0;
    cycles(1);
    check("idle_iready", {7'd0, iready}, 8'h01);

    // Latency, known values, 9-cycle accept period with oready tied high
    send(8'h53, 8'hCA);
    check("busy_iready", {7'd0, iready}, 8'h00);
    prev_acc = accept_cyc;
    send(8'h3D, 8'hBB);
    check_int("period_1", accept_cyc - prev_acc, 9);
    prev_acc = accept_cyc;
    send(8'h02, 8'h8D);
    check_int("period_2", accept_cyc - prev_acc, 9);
    prev_acc = accept_cyc;
    send(8'hFF, 8'h1C);
    check_int("period_3", accept_cyc - prev_acc, 9);
    send(8'h01, 8'h01);
    drain();
    check_int("ref_model_53", ref_inv(8'h53), 8'hCA);

    // Zero input
    send(8'h00, 8'h00);
    drain();
    check("zero_kept", odata, 8'h00);

    // Backpressure plus a held second request while busy
    oready = 1'b0;
    send(8'h53, 8'hCA);
    idata  = 8'h02;
    ivalid = 1'b1;
    n = 0;
    while (!ovalid && n < 50) begin
      @(negedge clk);
      if (!ovalid) check("busy_no_accept", {7'd0, iready}, 8'h00);
      n++;
    end
    if (!ovalid) fail_now("bp_ovalid_wait");
    repeat (5) begin
      @(negedge clk);
      check("bp_odata", odata, 8'hCA);
      check("bp_ovalid", {7'd0, ovalid}, 8'h01);
      check("bp_iready", {7'd0, iready}, 8'h00);
    end
    @(posedge clk);
    #1;
    oready = 1'b1;
    send(8'h02, 8'h8D);
    drain();

    // Reset three cycles into a computation
    rises = rise_count;
    send(8'h53, 8'hCA);
    cycles(2);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    exp_q.delete();
    in_q.delete();
    check("midrst_ovalid", {7'd0, ovalid}, 8'h00);
    check("midrst_iready", {7'd0, iready}, 8'h01);
    cycles(12);
    check_int("midrst_no_result", rise_count, rises);
    send(8'h3D, 8'hBB);
    drain();

    // Exhaustive sweep with random input gaps and random downstream stalls
    out_count = 0;
    acc_count = 0;
    fork
      begin
        for (int v = 0; v < 256; v++) begin
          cycles($urandom_range(0, 3));
          send(8'(v), ref_inv(8'(v)));
        end
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          @(posedge clk);
          #1;
          oready = 1'($urandom_range(0, 1));
        end
        oready = 1'b1;
      end
    join
    drain();
    check_int("sweep_accepts", acc_count, 256);
    check_int("sweep_outputs", out_count, 256);
    check_int("sweep_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
